vga_sync_gen: RTL and testbench

- Timing generator that sits directly upstream of the text/graphics pixel generators (font test, pong graphics).
- Divides the system clock down to a pixel-rate enable and runs the horizontal and vertical scan counters.
- Drives pixel_x, pixel_y, video_on, hsync, vsync, plus a pixel tick and a start-of-frame tick.
- All outputs are registered and mutually aligned, so downstream stages see a consistent (x, y, video_on) triple.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_sync_gen.sv | 119 +++++++++++
 tb/tb_vga_sync_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions.
// Purpose: default 640x480@60 timing constants, derived line/frame totals and
//          sync window positions. The sync generator and the downstream
//          text/graphics generators use these for region checks.
// Ports:   none (package).
package vga_timing_pkg;

    localparam int H_DISP_DEF = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;

    localparam int V_DISP_DEF = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOT_DEF = H_DISP_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;  // 800
    localparam int V_TOT_DEF = V_DISP_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;  // 525

    // Inclusive sync windows (656..751 and 490..491 at the defaults).
    localparam int H_SYNC_START_DEF = H_DISP_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
    localparam int V_SYNC_START_DEF = V_DISP_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

    // Scan position as seen by downstream pixel generators.
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } pixel_pos_t;

    // Drive level of a sync line given whether it is in its active window.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// VGA timing generator.
// Purpose: divides clk down to a pixel-rate advance, runs the horizontal and
//          vertical scan counters and produces registered, mutually aligned
//          position, blanking and sync outputs.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   hsync    out  horizontal sync (active level SYNC_POL)
//   vsync    out  vertical sync (active level SYNC_POL)
//   video_on out  current position lies in the visible area
//   p_tick   out  one-clk pulse: a new pixel position is valid this cycle
//   f_tick   out  one-clk pulse with p_tick when the position is (0,0)
//   pixel_x  out  horizontal count 0..H_TOT-1
//   pixel_y  out  vertical count 0..V_TOT-1
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int DIV      = 4,
    parameter int H_DISP   = H_DISP_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_DISP   = V_DISP_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       f_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_DISP);
    localparam logic [9:0]    V_VIS    = 10'(V_DISP);
    localparam logic [9:0]    HS_START = 10'(H_DISP + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0]    VS_START = 10'(V_DISP + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_cnt_reg, div_cnt_next;
    pixel_pos_t    pos_reg, pos_next;
    logic          adv;

    logic video_on_reg, video_on_next;
    logic hsync_reg, hsync_next;
    logic vsync_reg, vsync_next;
    logic p_tick_reg;
    logic f_tick_reg, f_tick_next;

    // Divider and scan counters. With DIV=1 div_cnt is stuck at 0, so adv
    // is high every clk.
    always_comb begin
        adv          = (div_cnt_reg == DIV_LAST);
        div_cnt_next = adv ? '0 : div_cnt_reg + 1'b1;
        pos_next     = pos_reg;
        if (adv) begin
            if (pos_reg.x == H_LAST) begin
                pos_next.x = '0;
                pos_next.y = (pos_reg.y == V_LAST) ? '0 : pos_reg.y + 10'd1;
            end else begin
                pos_next.x = pos_reg.x + 10'd1;
            end
        end
    end

    // Decode from the next-state position so the registered decode lines up
    // with the registered counters in the same cycle.
    always_comb begin
        video_on_next = (pos_next.x < H_VIS) && (pos_next.y < V_VIS);
        hsync_next    = sync_level((pos_next.x >= HS_START) && (pos_next.x <= HS_END),
                                   SYNC_POL);
        vsync_next    = sync_level((pos_next.y >= VS_START) && (pos_next.y <= VS_END),
                                   SYNC_POL);
        f_tick_next   = adv && (pos_next.x == '0) && (pos_next.y == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg  <= '0;
            pos_reg      <= '0;
            p_tick_reg   <= 1'b0;
            f_tick_reg   <= 1'b0;
            video_on_reg <= 1'b1;
            hsync_reg    <= ~SYNC_POL;
            vsync_reg    <= ~SYNC_POL;
        end else begin
            div_cnt_reg  <= div_cnt_next;
            pos_reg      <= pos_next;
            p_tick_reg   <= adv;
            f_tick_reg   <= f_tick_next;
            video_on_reg <= video_on_next;
            hsync_reg    <= hsync_next;
            vsync_reg    <= vsync_next;
        end
    end

    assign pixel_x  = pos_reg.x;
    assign pixel_y  = pos_reg.y;
    assign p_tick   = p_tick_reg;
    assign f_tick   = f_tick_reg;
    assign video_on = video_on_reg;
    assign hsync    = hsync_reg;
    assign vsync    = vsync_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: three instances (default 640x480 DIV=4,
// small geometry DIV=1 with active-high sync, small geometry DIV=3) share a
// randomly pulsed reset. A reference model derives every output from the
// number of non-reset clocks since the last reset; expectations are queued
// at each clock edge and a separate monitor pops and compares them.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       vo;
        logic       hs;
        logic       vs;
        logic       pt;
        logic       ft;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       a_hs, a_vs, a_vo, a_pt, a_ft;
    logic [9:0] a_x, a_y;
    logic       b_hs, b_vs, b_vo, b_pt, b_ft;
    logic [9:0] b_x, b_y;
    logic       c_hs, c_vs, c_vo, c_pt, c_ft;
    logic [9:0] c_x, c_y;

    vga_sync_gen #(.DIV(4)) dut_a (
        .clk(clk), .reset(reset), .hsync(a_hs), .vsync(a_vs), .video_on(a_vo),
        .p_tick(a_pt), .f_tick(a_ft), .pixel_x(a_x), .pixel_y(a_y)
    );

    vga_sync_gen #(.DIV(1), .H_DISP(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
                   .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1)) dut_b (
        .clk(clk), .reset(reset), .hsync(b_hs), .vsync(b_vs), .video_on(b_vo),
        .p_tick(b_pt), .f_tick(b_ft), .pixel_x(b_x), .pixel_y(b_y)
    );

    vga_sync_gen #(.DIV(3), .H_DISP(5), .H_FP(1), .H_SYNC(3), .H_BP(2),
                   .V_DISP(3), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0)) dut_c (
        .clk(clk), .reset(reset), .hsync(c_hs), .vsync(c_vs), .video_on(c_vo),
        .p_tick(c_pt), .f_tick(c_ft), .pixel_x(c_x), .pixel_y(c_y)
    );

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];
    int   checks = 0;
    int   errors = 0;
    longint n_clk = 0;   // non-reset edges since the last reset edge

    // Reference: after n non-reset clocks, floor(n/div) pixel advances have
    // happened; the position is that count folded into the frame raster.
    function automatic obs_t model(longint n, int div, int hd, int hf, int hs, int hb,
                                   int vd, int vf, int vs, int vb, bit pol);
        obs_t   o;
        int     ht = hd + hf + hs + hb;
        int     vt = vd + vf + vs + vb;
        longint p  = (n / div) % (ht * vt);
        int     x  = int'(p % ht);
        int     y  = int'(p / ht);
        o.x  = 10'(x);
        o.y  = 10'(y);
        o.vo = (x < hd) && (y < vd);
        o.hs = ((x >= hd + hf) && (x < hd + hf + hs)) ? pol : !pol;
        o.vs = ((y >= vd + vf) && (y < vd + vf + vs)) ? pol : !pol;
        o.pt = (n > 0) && (n % div == 0);
        o.ft = o.pt && (p == 0);
        return o;
    endfunction

    // Expectation producer: one entry per DUT per clock edge.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) n_clk = 0;
            else       n_clk = n_clk + 1;
            q_a.push_back(model(n_clk, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
            q_b.push_back(model(n_clk, 1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
            q_c.push_back(model(n_clk, 3, 5, 1, 3, 2, 3, 2, 1, 2, 1'b0));
        end
    end

    task automatic cmp(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s n=%0d got x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b ft=%b required x=%0d y=%0d vo=%b hs=%b vs=%b pt=%b ft=%b",
                         name, n_clk, got.x, got.y, got.vo, got.hs, got.vs, got.pt, got.ft,
                         exp.x, exp.y, exp.vo, exp.hs, exp.vs, exp.pt, exp.ft);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q_a.size() > 0)
                cmp("dut_a", {a_x, a_y, a_vo, a_hs, a_vs, a_pt, a_ft}, q_a.pop_front());
            if (q_b.size() > 0)
                cmp("dut_b", {b_x, b_y, b_vo, b_hs, b_vs, b_pt, b_ft}, q_b.pop_front());
            if (q_c.size() > 0)
                cmp("dut_c", {c_x, c_y, c_vo, c_hs, c_vs, c_pt, c_ft}, q_c.pop_front());
        end
    end

    // Stimulus: run segments of random length, each ended by a random-length
    // reset pulse that lands at an arbitrary point in the line/frame.
    initial begin
        int run_len;
        int rst_len;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            // First segment covers more than two full default lines.
            run_len = (s == 0) ? 7000 : int'($urandom_range(500, 4000));
            repeat (run_len) @(negedge clk);
            rst_len = int'($urandom_range(1, 3));
            $display("segment %0d: ran %0d clk, reset for %0d clk at a=(%0d,%0d)",
                     s, run_len, rst_len, a_x, a_y);
            reset = 1'b1;
            repeat (rst_len) @(negedge clk);
            reset = 1'b0;
        end
        repeat (3500) @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
